mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 34 +++
 rtl/mem_arbiter.sv | 106 ++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Two requester ports (pipeline A, loader B) plus the shared data-memory port.
// slave = arbiter side, master = requesters/memory side.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              a_req, a_we, a_done, a_stall;
   logic [ADDR_W-1:0] a_addr;
   logic [DATA_W-1:0] a_wdata, a_rdata;
   logic              b_req, b_we, b_done, b_gnt;
   logic [ADDR_W-1:0] b_addr;
   logic [DATA_W-1:0] b_wdata, b_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;
   logic              mem_we, mem_re;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      output a_rdata, a_done, a_stall,
      input  b_req, b_we, b_addr, b_wdata,
      output b_rdata, b_done, b_gnt,
      output mem_addr, mem_wdata, mem_we, mem_re,
      input  mem_rdata
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      input  a_rdata, a_done, a_stall,
      output b_req, b_we, b_addr, b_wdata,
      input  b_rdata, b_done, b_gnt,
      input  mem_addr, mem_wdata, mem_we, mem_re,
      output mem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter for a single LAT-cycle data memory (pipeline A, loader B).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed priority to A.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LAT    = 2
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, BUSY_A, BUSY_B} state_t;

   localparam logic [3:0] LAST = 4'(LAT - 1);

   state_t            r_state, w_next;
   logic [3:0]        r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_we;
   logic              r_a_done, r_b_done;
   logic [DATA_W-1:0] r_a_rdata, r_b_rdata;
   logic              w_a_elig, w_b_elig, w_pick_a, w_pick_b, w_last, w_busy;

   // A port is not eligible in its own done cycle, so its dropping req never re-grants.
   assign w_a_elig = bus.a_req & ~r_a_done;
   assign w_b_elig = bus.b_req & ~r_b_done;
   assign w_last   = (r_cnt == LAST);
   assign w_busy   = (r_state != IDLE);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic r_ptr_b;

   assign w_pick_a = w_a_elig & (~w_b_elig | ~r_ptr_b);

   always_ff @(posedge clk) begin
      if (rst)                             r_ptr_b <= 1'b0;
      else if (r_state == IDLE && w_pick_a) r_ptr_b <= 1'b1;
      else if (r_state == IDLE && w_pick_b) r_ptr_b <= 1'b0;
   end
`else
   assign w_pick_a = w_a_elig;
`endif
   assign w_pick_b = w_b_elig & ~w_pick_a;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (w_pick_a)      w_next = BUSY_A;
            else if (w_pick_b) w_next = BUSY_B;
         end
         default: if (w_last) w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= 4'd0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_we      <= 1'b0;
         r_a_done  <= 1'b0;
         r_b_done  <= 1'b0;
         r_a_rdata <= '0;
         r_b_rdata <= '0;
      end else begin
         r_state  <= w_next;
         r_a_done <= (r_state == BUSY_A) && w_last;
         r_b_done <= (r_state == BUSY_B) && w_last;
         case (r_state)
            IDLE: begin
               r_cnt <= 4'd0;
               if (w_pick_a) begin
                  r_addr  <= bus.a_addr;
                  r_wdata <= bus.a_wdata;
                  r_we    <= bus.a_we;
               end else if (w_pick_b) begin
                  r_addr  <= bus.b_addr;
                  r_wdata <= bus.b_wdata;
                  r_we    <= bus.b_we;
               end
            end
            default: begin
               r_cnt <= r_cnt + 4'd1;
               if (w_last && !r_we) begin
                  if (r_state == BUSY_A) r_a_rdata <= bus.mem_rdata;
                  else                   r_b_rdata <= bus.mem_rdata;
               end
            end
         endcase
      end
   end

   assign bus.mem_addr  = w_busy ? r_addr  : '0;
   assign bus.mem_wdata = w_busy ? r_wdata : '0;
   assign bus.mem_we    = w_busy &  r_we;
   assign bus.mem_re    = w_busy & ~r_we;
   assign bus.a_rdata   = r_a_rdata;
   assign bus.a_done    = r_a_done;
   assign bus.a_stall   = bus.a_req & ~r_a_done;
   assign bus.b_rdata   = r_b_rdata;
   assign bus.b_done    = r_b_done;
   assign bus.b_gnt     = (r_state == BUSY_B);
endmodule
